// File: rtl/muldiv_ctrl_if.sv
// Issue/result bus between the single-cycle datapath and the HI/LO multiply/divide sequencer.
//
// Handshake: start is a request that the datapath keeps asserting, with op/a/b stable,
// until it is taken. The sequencer takes it on any rising edge where busy is low; a
// request seen while busy is refused, and stall (= busy & (start | rd_req)) freezes the
// datapath so the same request appears again next cycle. op/a/b are sampled only on the
// accepting edge. rd_req never changes sequencer state. It only raises stall while busy,
// so a read of hi/lo goes ahead only once they hold the final value.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             busy;
  logic             stall;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, rd_req,
    input  busy, stall, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_req,
    output busy, stall, done, dz, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// It uses shift-add multiply (LSB-first) and restoring divide (MSB-first), one step per
// cycle. Both work on magnitudes, and a single FIX cycle applies the sign correction.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus,
  output logic [1:0]    state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;       // mul: {partial sum, multiplier}; div: low half = dividend/quotient
  logic [WIDTH-1:0]   rem;       // partial remainder, always below the divisor
  logic [WIDTH-1:0]   oper;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   orig_a;    // untouched dividend, returned in HI on divide-by-zero
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dz_q;

  // Operand decode at issue time
  logic             md_op;
  logic             sgn_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign md_op  = (bus.op[2] == 1'b0);
  assign sgn_op = ~bus.op[0];
  assign abs_a  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One iteration step: shift-add for multiply, trial subtract for divide
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : {(WIDTH+1){1'b0}});
  assign rem_sh  = {rem, acc[WIDTH-1]};
  assign div_ge  = (rem_sh >= {1'b0, oper});
  // When div_ge holds, the true difference is below the divisor, so WIDTH bits suffice
  assign div_sub = rem_sh[WIDTH-1:0] - oper;

  // Sign fixup applied in FIX
  logic               neg;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quot_f;
  logic [WIDTH-1:0]   rem_f;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign neg    = sign_a ^ sign_b;
  assign prod_f = neg ? -acc : acc;
  assign quot_f = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_f  = sign_a ? -rem : rem;
  assign fix_hi = !is_div ? prod_f[2*WIDTH-1:WIDTH] : (div_zero ? orig_a : rem_f);
  assign fix_lo = !is_div ? prod_f[WIDTH-1:0] : (div_zero ? {WIDTH{1'b1}} : quot_f);

  // Sequencer FSM together with the HI/LO and done/dz registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      oper     <= '0;
      orig_a   <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (md_op) begin
              is_div   <= bus.op[1];
              sign_a   <= sgn_op & bus.a[WIDTH-1];
              sign_b   <= sgn_op & bus.b[WIDTH-1];
              div_zero <= bus.op[1] && (bus.b == '0);
              orig_a   <= bus.a;
              cnt      <= '0;
              rem      <= '0;
              if (bus.op[1]) begin
                oper <= abs_b;
                acc  <= {{WIDTH{1'b0}}, abs_a};
              end else begin
                oper <= abs_a;
                acc  <= {{WIDTH{1'b0}}, abs_b};
              end
              state <= RUN;
            end else if (bus.op == 3'b100) begin
              hi_q <= bus.a;
            end else if (bus.op == 3'b101) begin
              lo_q <= bus.a;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            if (div_ge) begin
              rem            <= div_sub;
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
            end else begin
              rem            <= rem_sh[WIDTH-1:0];
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          dz_q   <= is_div & div_zero;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic busy;
  assign busy      = (state != IDLE);
  assign bus.busy  = busy;
  assign bus.stall = busy & (bus.start | bus.rd_req);
  assign bus.done  = done_q;
  assign bus.dz    = dz_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl. A vector table covers the arithmetic. Hand-written
// sequences cover stall, held start, MTHI/MTLO ordering and reset in the middle of an op.
module tb_muldiv_ctrl;
  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and leave it for one accepting edge; returns 1ns after that edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen (bounded)
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.done && cyc < 200);
    if (!bus.done) begin
      n_total++;
      $display("FAIL %s: done timeout got %0d cycles required %0d", name, cyc, W + 1);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int cyc;
    logic [2*W-1:0] e;
    issue(v.op, v.a, v.b);
    check({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
    exp_q.push_back({v.hi, v.lo});
    wait_done(name, cyc);
    e = exp_q.pop_front();
    check({name, "_lat"}, cyc, W + 1);
    check({name, "_hi"}, bus.hi, e[2*W-1:W]);
    check({name, "_lo"}, bus.lo, e[W-1:0]);
    check({name, "_dz"}, {31'b0, bus.dz}, {31'b0, v.dz});
    check({name, "_idle"}, {31'b0, bus.busy}, 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int   k;
    int   cyc;
    logic bad;
    logic seen;

    tbl[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[4] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{OP_DIV,   32'd100,      32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0};
    tbl[6] = '{OP_DIV,   32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[8] = '{OP_MULT,  32'd6,        32'd7,        32'd0,         32'd42,        1'b0};
    tbl[9] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,         32'd14,        1'b0};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 3'b111;
    bus.a      = '0;
    bus.b      = '0;
    bus.rd_req = 1'b0;
    repeat (2) step();
    check("rst_hi",   bus.hi, 32'd0);
    check("rst_lo",   bus.lo, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_dz",   {31'b0, bus.dz}, 32'd0);
    reset = 1'b0;
    step();

    // Arithmetic table
    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Ignored op codes leave HI/LO alone
    issue(3'b110, 32'hDEAD_BEEF, 32'd1);
    check("noop_busy", {31'b0, bus.busy}, 32'd0);
    check("noop_lo", bus.lo, 32'd14);
    check("noop_hi", bus.hi, 32'd2);

    // rd_req during MULT 6*7: stall held until busy falls, then new LO visible
    issue(OP_MULT, 32'd6, 32'd7);
    step();
    step();
    bus.rd_req = 1'b1;
    step();
    bad = 1'b0;
    k = 0;
    while (bus.busy && k < 100) begin
      if (!bus.stall) bad = 1'b1;
      step();
      k++;
    end
    check("rd_stall_held", {31'b0, bad}, 32'd0);
    check("rd_busy_fell", {31'b0, bus.busy}, 32'd0);
    check("rd_release_stall", {31'b0, bus.stall}, 32'd0);
    check("rd_release_done", {31'b0, bus.done}, 32'd1);
    check("rd_release_lo", bus.lo, 32'd42);
    bus.rd_req = 1'b0;
    step();

    // Second start held through busy is accepted on the done cycle
    issue(OP_MULTU, 32'd3, 32'd5);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'hFFFF_FFFE;
    bus.b     = 32'd9;
    bad = 1'b0;
    k = 0;
    do begin
      step();
      k++;
      if (bus.busy && !bus.stall) bad = 1'b1;
    end while (!bus.done && k < 100);
    check("hold_stall", {31'b0, bad}, 32'd0);
    check("hold_first_lat", k, W + 1);
    check("hold_first_lo", bus.lo, 32'd15);
    check("hold_first_hi", bus.hi, 32'd0);
    check("hold_done_nostall", {31'b0, bus.stall}, 32'd0);
    step();
    bus.start = 1'b0;
    check("hold_accepted", {31'b0, bus.busy}, 32'd1);
    wait_done("hold_second", cyc);
    check("hold_second_lat", cyc, W + 1);
    check("hold_second_hi", bus.hi, 32'hFFFF_FFFF);
    check("hold_second_lo", bus.lo, 32'hFFFF_FFEE);
    step();

    // MTLO in idle: next-edge write, no busy, no done
    issue(OP_MTLO, 32'h0000_1234, 32'd0);
    check("mtlo_lo", bus.lo, 32'h0000_1234);
    check("mtlo_hi_kept", bus.hi, 32'hFFFF_FFFF);
    check("mtlo_busy", {31'b0, bus.busy}, 32'd0);
    check("mtlo_done", {31'b0, bus.done}, 32'd0);
    step();
    check("mtlo_done_later", {31'b0, bus.done}, 32'd0);

    // MTHI during busy is stalled, then overrides HI after the MULT completes
    issue(OP_MULT, 32'd6, 32'd7);
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.a     = 32'h0000_ABCD;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.done && k < 100);
    check("mthi_result_hi", bus.hi, 32'd0);
    check("mthi_result_lo", bus.lo, 32'd42);
    step();
    bus.start = 1'b0;
    check("mthi_hi", bus.hi, 32'h0000_ABCD);
    check("mthi_lo", bus.lo, 32'd42);
    check("mthi_busy", {31'b0, bus.busy}, 32'd0);
    check("mthi_done", {31'b0, bus.done}, 32'd0);

    // Reset in the middle of a DIVU discards it
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) step();
    check("mid_busy", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("mid_rst_hi", bus.hi, 32'd0);
    check("mid_rst_lo", bus.lo, 32'd0);
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("mid_no_done", {31'b0, seen}, 32'd0);
    run_vec("post_rst", tbl[9]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
